// File: rtl/timer_mmss_updown_pkg.sv
// timer_pkg: shared types and constants for the MM:SS up/down timer.
//   state_t      controller states IDLE / RUN / PAUSE / DONE (2-bit)
//   SEG_TABLE    BCD digit 0..9 to active-low 7-segment code, dp off
//   SEG_BLANK    all segments off
//   clamp_bcd    forces a raw two-digit BCD value into a legal range
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry [n] is the pattern for digit n; bit 7 (dp) is kept off here.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    if (digit > 4'd9) return SEG_BLANK;
    return SEG_TABLE[digit];
  endfunction

  // Digits above 9 become 9, the tens digit is capped at tens_max, and
  // the whole value is then capped at max_bcd (valid BCD compares
  // correctly as a plain binary number).
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v,
                                           input logic [3:0] tens_max,
                                           input logic [7:0] max_bcd);
    logic [3:0] t;
    logic [3:0] u;
    t = (v[7:4] > tens_max) ? tens_max : v[7:4];
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    if ({t, u} > max_bcd) return max_bcd;
    return {t, u};
  endfunction

endpackage

// File: rtl/timer_mmss_updown_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MODULUS.
//   clock, reset      system clock, async active-high reset
//   inc, dec          step up / down by one (inc has priority)
//   load, load_value  synchronous load, overrides inc/dec
//   value             registered count
//   next_value        value the register takes at the next edge
//   carry, borrow     high while an inc wraps MAX->0 / a dec wraps 0->MAX
module bcd_mod_counter #(
  parameter int MODULUS = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] value,
  output logic [7:0] next_value,
  output logic       carry,
  output logic       borrow
);

  localparam logic [7:0] MAX_BCD = {4'((MODULUS - 1) / 10), 4'((MODULUS - 1) % 10)};

  always_comb begin
    next_value = value;
    carry      = 1'b0;
    borrow     = 1'b0;
    if (load) begin
      next_value = load_value;
    end else if (inc) begin
      if (value == MAX_BCD) begin
        next_value = 8'h00;
        carry      = 1'b1;
      end else if (value[3:0] == 4'd9) begin
        next_value = {value[7:4] + 4'd1, 4'd0};
      end else begin
        next_value = {value[7:4], value[3:0] + 4'd1};
      end
    end else if (dec) begin
      if (value == 8'h00) begin
        next_value = MAX_BCD;
        borrow     = 1'b1;
      end else if (value[3:0] == 4'd0) begin
        next_value = {value[7:4] - 4'd1, 4'd9};
      end else begin
        next_value = {value[7:4], value[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) value <= 8'h00;
    else       value <= next_value;
  end

endmodule

// File: rtl/timer_mmss_updown.sv
// timer_mmss_updown: MM:SS BCD timer counting down from a loaded value or
// up toward a loaded target, with a 4-digit multiplexed 7-segment display.
//   clock, reset        system clock, async active-high reset
//   btn_ss, btn_load    raw start/stop and load buttons
//   mode                0 = down, 1 = up; captured on load
//   min_in, sec_in      BCD load value
//   min_bcd, sec_bcd    current count
//   running, done       high in RUN / DONE
//   an, seg             active-low digit enables and segments (seg[7] = dp)
// Optional: define TIMER_BLINK_EN to blank the display for the second half
// of every second while in PAUSE or DONE.
module timer_mmss_updown
  import timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int SCAN_DIV    = 50_000,
  parameter int MAX_MIN     = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_load,
  input  logic       mode,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int PRESC_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  state_t state_q, state_d;
  logic [1:0] ss_sync, load_sync;
  logic ss_prev, load_prev, ss_pulse, load_pulse;
  logic mode_q;
  logic [7:0] target_min, target_sec, clamp_min, clamp_sec;
  logic [7:0] end_min, end_sec, min_next, sec_next, load_min, load_sec;
  logic load_ok, reload_done, cnt_load, tick, at_end, tick_end;
  logic sec_carry, sec_borrow, min_carry, min_borrow;
  logic [PRESC_W-1:0] presc_q;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0] scan_idx;
  logic [3:0] digit;
  logic blink_off;

  // Button conditioning: the edge pulse is seen on the second edge and
  // acted on at the third edge after the raw rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_sync   <= 2'b00;
      load_sync <= 2'b00;
      ss_prev   <= 1'b0;
      load_prev <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[0], btn_ss};
      load_sync <= {load_sync[0], btn_load};
      ss_prev   <= ss_sync[1];
      load_prev <= load_sync[1];
    end
  end

  assign ss_pulse   = ss_sync[1] & ~ss_prev;
  assign load_pulse = load_sync[1] & ~load_prev;

  assign clamp_min = clamp_bcd(min_in, 4'd9, MAX_MIN_BCD);
  assign clamp_sec = clamp_bcd(sec_in, 4'd5, 8'h59);

  // A load outside RUN always wins; start/stop from DONE reloads the
  // count from the stored target and mode.
  assign load_ok     = load_pulse && (state_q != RUN);
  assign reload_done = !load_ok && ss_pulse && (state_q == DONE);
  assign cnt_load    = load_ok || reload_done;
  assign load_min    = load_ok ? (mode ? 8'h00 : clamp_min) : (mode_q ? 8'h00 : target_min);
  assign load_sec    = load_ok ? (mode ? 8'h00 : clamp_sec) : (mode_q ? 8'h00 : target_sec);

  assign tick     = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign end_min  = mode_q ? target_min : 8'h00;
  assign end_sec  = mode_q ? target_sec : 8'h00;
  assign at_end   = ({min_bcd, sec_bcd} == {end_min, end_sec});
  assign tick_end = ({min_next, sec_next} == {end_min, end_sec});

  bcd_mod_counter #(.MODULUS(60)) u_sec (
    .clock(clock), .reset(reset),
    .inc(tick & mode_q), .dec(tick & ~mode_q),
    .load(cnt_load), .load_value(load_sec),
    .value(sec_bcd), .next_value(sec_next),
    .carry(sec_carry), .borrow(sec_borrow)
  );

  bcd_mod_counter #(.MODULUS(MAX_MIN + 1)) u_min (
    .clock(clock), .reset(reset),
    .inc(sec_carry), .dec(sec_borrow),
    .load(cnt_load), .load_value(load_min),
    .value(min_bcd), .next_value(min_next),
    .carry(min_carry), .borrow(min_borrow)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      target_min <= 8'h00;
      target_sec <= 8'h00;
    end else begin
      state_q <= state_d;
      if (load_ok) begin
        mode_q     <= mode;
        target_min <= clamp_min;
        target_sec <= clamp_sec;
      end
    end
  end

  // A minutes wrap can only follow an out-of-range count; it is treated
  // as reaching the end so the display never rolls through.
  always_comb begin
    state_d = state_q;
    if (load_ok) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ss_pulse && !at_end) state_d = RUN;
        RUN: begin
          if (tick && (tick_end || min_carry || min_borrow)) state_d = DONE;
          else if (ss_pulse)                                  state_d = PAUSE;
        end
        PAUSE:   if (ss_pulse) state_d = RUN;
        DONE:    if (ss_pulse) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Cleared on RUN entry so the first change lands CLK_FREQ_HZ cycles later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   presc_q <= '0;
    else if (state_d == RUN && state_q != RUN)   presc_q <= '0;
    else if (state_q == RUN)                     presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= 2'd0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

`ifdef TIMER_BLINK_EN
  localparam logic [PRESC_W-1:0] BLINK_HALF = PRESC_W'(CLK_FREQ_HZ / 2);
  logic [PRESC_W-1:0] blink_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      blink_cnt <= '0;
    else if (blink_cnt == PRESC_MAX) blink_cnt <= '0;
    else                            blink_cnt <= blink_cnt + 1'b1;
  end

  assign blink_off = ((state_q == PAUSE) || (state_q == DONE)) && (blink_cnt >= BLINK_HALF);
`else
  assign blink_off = 1'b0;
`endif

  always_comb begin
    digit = 4'd0;
    case (scan_idx)
      2'd0: digit = sec_bcd[3:0];
      2'd1: digit = sec_bcd[7:4];
      2'd2: digit = min_bcd[3:0];
      2'd3: digit = min_bcd[7:4];
      default: digit = 4'd0;
    endcase
  end

  // The decimal point separates minutes from seconds, so it sits on the
  // minutes-units digit; invalid codes stay fully blank.
  always_comb begin
    an  = ~(4'b0001 << scan_idx);
    seg = seg_decode(digit);
    if (scan_idx == 2'd2 && digit <= 4'd9) seg[7] = 1'b0;
    if (blink_off) seg = SEG_BLANK;
  end

endmodule
